// File: rtl/game_controls_mp.sv
// Multiplayer game control front end: synchronises and debounces six buttons,
// turns presses into action pulses with auto-repeat, and sequences player turns.
module game_controls_mp #(
  parameter int NUM_PLAYERS   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4,
  parameter int LOCK_CYCLES   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic move_left,
  input  logic move_right,
  input  logic aim_left,
  input  logic aim_right,
  input  logic shoot,
  input  logic start_new_game,
  output logic left_x,
  output logic right_x,
  output logic left_aim,
  output logic right_aim,
  output logic shoot_out,
  output logic [4:0] select,
  output logic [((NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1)-1:0] player,
  output logic playing
);
  localparam int PW    = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int SHOOT = 4;
  localparam int START = 5;

  typedef enum logic [1:0] {IDLE, PLAY, LOCK} state_t;

  state_t     state, next_state;
  logic [5:0] raw, sync1, sync2, db, db_d, press;
  logic [7:0] db_cnt [6];
  logic [3:0] blocked, rpt_active, rpt_first;
  logic [7:0] rpt_cnt [4];
  logic [7:0] lock_cnt;
  logic [4:0] fire;

  // Bit order matches select, with start_new_game appended on top.
  assign raw = {start_new_game, shoot, aim_right, aim_left, move_right, move_left};

  // A pair with both buttons held is silenced entirely.
  assign blocked = {{2{db_d[3] & db_d[2]}}, {2{db_d[1] & db_d[0]}}};
  assign playing = (state == PLAY) || (state == LOCK);

  function automatic logic [4:0] top_bit(input logic [4:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) if (v[i]) r = 5'b00001 << i;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      press <= '0;
      // NOTE: the counter array is part of the debouncer state, so it is cleared
      // element by element like any other register rather than left to power-up.
      for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking updates let the synchroniser chain shift by exactly one
      // stage per edge; blocking ones would collapse it into a single flop.
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      press <= db & ~db_d;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == 8'(DB_CYCLES - 1)) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    next_state = state;
    fire       = '0;
    case (state)
      PLAY: begin
        for (int i = 0; i < 4; i++)
          fire[i] = !blocked[i] && (press[i] || (rpt_active[i] && db_d[i] &&
                    rpt_cnt[i] == (rpt_first[i] ? 8'(REPEAT_DELAY) : 8'(REPEAT_PERIOD))));
        fire[SHOOT] = press[SHOOT];
        if (press[SHOOT]) next_state = LOCK;
      end
      LOCK: if (lock_cnt == 8'(LOCK_CYCLES - 1)) next_state = PLAY;
      default: ;
    endcase
    if (press[START]) begin
      next_state = PLAY;
      fire       = '0;
    end
  end

  // rpt_cnt holds cycles since the last pulse; it is reloaded on every pulse,
  // so it never climbs past its target and cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_active <= '0;
      rpt_first  <= '0;
      for (int i = 0; i < 4; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (press[START] || state != PLAY || blocked[i] || !db_d[i]) begin
          rpt_active[i] <= 1'b0;
          rpt_first[i]  <= 1'b0;
          rpt_cnt[i]    <= '0;
        end else if (fire[i]) begin
          rpt_active[i] <= 1'b1;
          rpt_first[i]  <= press[i];
          rpt_cnt[i]    <= 8'd1;
        end else if (rpt_active[i]) begin
          rpt_cnt[i] <= rpt_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      player   <= '0;
      select   <= '0;
      lock_cnt <= '0;
      {shoot_out, right_aim, left_aim, right_x, left_x} <= '0;
    end else begin
      {shoot_out, right_aim, left_aim, right_x, left_x} <= fire;
      if (press[START]) begin
        player   <= '0;
        select   <= '0;
        lock_cnt <= '0;
      end else if (state == PLAY) begin
        lock_cnt <= '0;
        if (fire != '0) select <= top_bit(fire);
      end else if (state == LOCK) begin
        if (next_state == PLAY) begin
          lock_cnt <= '0;
          select   <= '0;
          player   <= (player == PW'(NUM_PLAYERS - 1)) ? '0 : player + PW'(1);
        end else begin
          lock_cnt <= lock_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_controls_mp.sv
// Bench for game_controls_mp: directed timing scenarios plus random stimulus,
// scored against an absolute-time behavioural model; a second instance covers 3 players.
module tb_game_controls_mp;
  localparam int DB = 4, RD = 16, RP = 4, LK = 8;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [5:0] btn    = '0;   // {start, shoot, aim_right, aim_left, move_right, move_left}
  logic       left_x, right_x, left_aim, right_aim, shoot_out, playing;
  logic [4:0] select;
  logic       player;

  logic       reset2 = 1'b1;
  logic [5:0] btn2   = '0;
  logic       left_x2, right_x2, left_aim2, right_aim2, shoot_out2, playing2;
  logic [4:0] select2;
  logic [1:0] player2;

  int checks = 0;
  int failures = 0;

  game_controls_mp dut (
    .clk(clk), .reset(reset),
    .move_left(btn[0]), .move_right(btn[1]), .aim_left(btn[2]), .aim_right(btn[3]),
    .shoot(btn[4]), .start_new_game(btn[5]),
    .left_x(left_x), .right_x(right_x), .left_aim(left_aim), .right_aim(right_aim),
    .shoot_out(shoot_out), .select(select), .player(player), .playing(playing)
  );

  game_controls_mp #(.NUM_PLAYERS(3), .DB_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset2),
    .move_left(btn2[0]), .move_right(btn2[1]), .aim_left(btn2[2]), .aim_right(btn2[3]),
    .shoot(btn2[4]), .start_new_game(btn2[5]),
    .left_x(left_x2), .right_x(right_x2), .left_aim(left_aim2), .right_aim(right_aim2),
    .shoot_out(shoot_out2), .select(select2), .player(player2), .playing(playing2)
  );

  always #5 clk = ~clk;

  // Reference model: debounced levels plus absolute-time schedules for repeats and lock end.
  logic [5:0] m_s1, m_s2, m_db;
  logic [5:0] m_dh [3];
  int         m_run [6];
  int         m_next [4];
  int         m_mode, m_lock_end, m_player, t_now = 0;
  logic [4:0] m_select, m_fire;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int i = 0; i < 3; i++) m_dh[i] = '0;
    for (int i = 0; i < 6; i++) m_run[i] = 0;
    for (int i = 0; i < 4; i++) m_next[i] = -1;
    m_mode = 0; m_lock_end = -1; m_player = 0; m_select = '0; m_fire = '0;
  endtask

  task automatic model_step(input logic [5:0] raw, input logic rst);
    logic [5:0] held, prs;
    t_now++;
    if (rst) begin
      model_clear();
      return;
    end
    held   = m_dh[1];
    prs    = m_dh[1] & ~m_dh[2];
    m_fire = '0;
    if (prs[5]) begin
      m_mode = 1; m_player = 0; m_select = '0;
      for (int i = 0; i < 4; i++) m_next[i] = -1;
    end else if (m_mode == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (!held[i] || held[i ^ 1]) m_next[i] = -1;
        else if (prs[i]) begin m_fire[i] = 1'b1; m_next[i] = t_now + RD; end
        else if (m_next[i] == t_now) begin m_fire[i] = 1'b1; m_next[i] = t_now + RP; end
      end
      if (prs[4]) begin
        m_fire[4] = 1'b1; m_mode = 2; m_lock_end = t_now + LK;
        for (int i = 0; i < 4; i++) m_next[i] = -1;
      end
      for (int i = 0; i < 5; i++) if (m_fire[i]) begin m_select = '0; m_select[i] = 1'b1; end
    end else if (m_mode == 2 && t_now == m_lock_end) begin
      m_mode = 1; m_select = '0; m_player = (m_player + 1) % 2;
    end
    for (int i = 0; i < 6; i++) begin
      if (m_s2[i] == m_db[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DB) begin m_db[i] = ~m_db[i]; m_run[i] = 0; end
      end
    end
    m_s2 = m_s1; m_s1 = raw;
    m_dh[2] = m_dh[1]; m_dh[1] = m_dh[0]; m_dh[0] = m_db;
  endtask

  function automatic logic [11:0] obs();
    return {shoot_out, right_aim, left_aim, right_x, left_x, select, player, playing};
  endfunction

  function automatic logic [11:0] exp_obs();
    return {m_fire, m_select, 1'(m_player), m_mode != 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(btn, reset);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (obs() !== 12'h000) begin
        failures++; $display("FAIL reset_state k=%0d got=%h want=%h", k, obs(), 12'h000);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_start_glitch();
    for (int k = 0; k < 20; k++) begin
      btn[5] = (k < 10);
      tick();
      checks++;
      if (obs() !== exp_obs()) begin
        failures++; $display("FAIL start_model k=%0d got=%h want=%h", k, obs(), exp_obs());
      end
      if (k == 6 || k == 7) begin
        checks++;
        if (playing !== (k == 7) || player !== 1'b0) begin
          failures++; $display("FAIL start_latency k=%0d got=%b/%b want=%b/0", k, playing, player, k == 7);
        end
      end
    end
    for (int k = 0; k < 15; k++) begin
      btn[0] = (k == 0);
      tick();
      checks++;
      if (left_x !== 1'b0 || obs() !== exp_obs()) begin
        failures++; $display("FAIL glitch k=%0d got=%h want=%h", k, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_repeat();
    logic want;
    for (int k = 0; k < 56; k++) begin
      btn[3] = (k < 40);
      tick();
      checks++;
      if (obs() !== exp_obs()) begin
        failures++; $display("FAIL repeat_model k=%0d got=%h want=%h", k, obs(), exp_obs());
      end
      if (k <= 40) begin
        want = (k == 7) || (k == 23) || (k == 27) || (k == 31) || (k == 35) || (k == 39);
        checks++;
        if (right_aim !== want) begin
          failures++; $display("FAIL repeat_timing k=%0d got=%b want=%b", k, right_aim, want);
        end
      end
      if (k == 39) begin
        checks++;
        if (select !== 5'b01000) begin
          failures++; $display("FAIL repeat_select got=%b want=01000", select);
        end
      end
    end
  endtask

  task automatic test_conflict();
    for (int k = 0; k < 45; k++) begin
      btn[0] = (k < 30); btn[1] = (k < 30);
      tick();
      checks++;
      if (left_x !== 1'b0 || right_x !== 1'b0 || obs() !== exp_obs()) begin
        failures++; $display("FAIL conflict k=%0d got=%h want=%h", k, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_shoot_lock();
    for (int k = 0; k < 53; k++) begin
      btn[4] = (k < 6) || (k >= 30 && k < 36);
      btn[2] = (k >= 2 && k < 8);
      tick();
      checks++;
      if (obs() !== exp_obs()) begin
        failures++; $display("FAIL shoot_model k=%0d got=%h want=%h", k, obs(), exp_obs());
      end
      checks++;
      if (shoot_out !== (k == 7 || k == 37) || left_aim !== 1'b0) begin
        failures++; $display("FAIL shoot_pulse k=%0d got=%b/%b want=%b/0", k, shoot_out, left_aim, k == 7 || k == 37);
      end
      if (k == 7 || k == 14 || k == 15 || k == 44 || k == 45) begin
        checks++;
        if ((k == 7 && select !== 5'b10000) || (k == 14 && player !== 1'b0) ||
            (k == 15 && (player !== 1'b1 || select !== 5'b00000)) ||
            (k == 44 && player !== 1'b1) || (k == 45 && player !== 1'b0)) begin
          failures++; $display("FAIL lock_turn k=%0d got player=%b select=%b", k, player, select);
        end
      end
    end
  endtask

  task automatic test_hold_across_lock();
    for (int k = 0; k < 56; k++) begin
      btn[4] = (k < 6);
      btn[1] = (k >= 2 && k < 30) || (k >= 40 && k < 46);
      tick();
      checks++;
      if (right_x !== (k == 47) || obs() !== exp_obs()) begin
        failures++; $display("FAIL hold_lock k=%0d got=%h want=%h", k, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 80; k++) begin
      btn[2] = (k < 70);
      btn[5] = (k >= 40 && k < 50);
      reset  = (k == 28 || k == 29);
      tick();
      checks++;
      if (left_aim !== (k == 7 || k == 23 || k == 27) || obs() !== exp_obs()) begin
        failures++; $display("FAIL reset_repeat k=%0d got=%h want=%h", k, obs(), exp_obs());
      end
      if (k == 28 || k == 46 || k == 47) begin
        checks++;
        if ((k == 28 && obs() !== 12'h000) || (k == 46 && playing !== 1'b0) || (k == 47 && playing !== 1'b1)) begin
          failures++; $display("FAIL reset_idle k=%0d got=%h", k, obs());
        end
      end
    end
    for (int k = 0; k < 25; k++) begin
      btn[4] = (k < 6);
      reset  = (k == 10);
      tick();
      checks++;
      if (obs() !== exp_obs() || (k == 10 && obs() !== 12'h000) || (k == 12 && playing !== 1'b0)) begin
        failures++; $display("FAIL reset_lock k=%0d got=%h want=%h", k, obs(), exp_obs());
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    btn = '0;
    for (int k = 0; k < 820; k++) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 99) < 6) btn[i] = ~btn[i];
      if ($urandom_range(0, 199) < 2) btn[5] = ~btn[5];
      if (k < 10) btn[5] = 1'b1;
      else if (k == 10) btn[5] = 1'b0;
      reset = (k < 800) && ($urandom_range(0, 499) == 0);
      if (k >= 800) btn = '0;
      tick();
      checks++;
      if (obs() !== exp_obs()) begin
        failures++; $display("FAIL random k=%0d btn=%b got=%h want=%h", k, btn, obs(), exp_obs());
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_dut2();
    reset2 = 1'b1; btn2 = '0;
    tick(); tick();
    reset2 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      btn2[5] = (k < 4);
      tick();
      if (k == 3 || k == 4) begin
        checks++;
        if (playing2 !== (k == 4)) begin
          failures++; $display("FAIL dut2_start k=%0d got=%b want=%b", k, playing2, k == 4);
        end
      end
    end
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 20; k++) begin
        btn2[4] = (k < 3);
        tick();
        checks++;
        if (shoot_out2 !== (k == 4)) begin
          failures++; $display("FAIL dut2_shoot n=%0d k=%0d got=%b want=%b", n, k, shoot_out2, k == 4);
        end
        if (k == 11 || k == 12) begin
          checks++;
          if (player2 !== 2'((k == 12) ? (n + 1) % 3 : n)) begin
            failures++; $display("FAIL dut2_player n=%0d k=%0d got=%0d want=%0d", n, k, player2,
                                 (k == 12) ? (n + 1) % 3 : n);
          end
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_start_glitch();
    test_repeat();
    test_conflict();
    test_shoot_lock();
    test_hold_across_lock();
    test_reset_mid();
    test_random();
    test_dut2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
